// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a head/skid output buffer.
// Modes: sign, zero, upper placement, shifted branch offset.
module imm_extend_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] ext;

  logic             head_vld;
  logic [OUT_W-1:0] head_q;
  logic             skid_vld;
  logic [OUT_W-1:0] skid_q;

  logic in_fire;
  logic head_free;

  assign sext  = {{PAD{in_data[IN_W-1]}}, in_data};
  assign zext  = {{PAD{1'b0}}, in_data};
  assign upper = {in_data, {PAD{1'b0}}};

  always_comb begin
    ext = sext;
    unique case (in_mode)
      2'b00: ext = sext;
      2'b01: ext = zext;
      2'b10: ext = upper;
      2'b11: ext = sext << BR_SHIFT;
    endcase
  end

  // in_ready comes straight from a flop, so out_ready never reaches it
  assign in_ready  = ~skid_vld;
  assign in_fire   = in_valid & in_ready;
  assign head_free = ~head_vld | out_ready;

  assign out_valid = head_vld;
  assign out_data  = head_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_vld <= 1'b0;
      head_q   <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
    end else if (head_free) begin
      if (skid_vld) begin
        head_vld <= 1'b1;
        head_q   <= skid_q;
        skid_vld <= in_fire;
        if (in_fire) skid_q <= ext;
      end else if (in_fire) begin
        head_vld <= 1'b1;
        head_q   <= ext;
      end else begin
        head_vld <= 1'b0;
      end
    end else if (in_fire) begin
      skid_vld <= 1'b1;
      skid_q   <= ext;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: queue model, per-cycle compare,
// directed vectors, and a second instance with narrow widths.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_data = '0;
  logic [1:0]  b_in_mode = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_out_data;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data)
  );

  // Extension by arithmetic on integers, modulo 2^ow
  function automatic logic [63:0] model(int iw, int ow, int bs,
                                        logic [63:0] d, logic [1:0] m);
    logic [63:0] md;
    logic [63:0] s;
    md = 64'd1 << ow;
    d  = d % (64'd1 << iw);
    s  = (d >= (64'd1 << (iw - 1))) ? d + md - (64'd1 << iw) : d;
    case (m)
      2'd0:    return s;
      2'd1:    return d;
      2'd2:    return (d * (64'd1 << (ow - iw))) % md;
      default: return (s * (64'd1 << bs)) % md;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Occupancy model: a two-deep FIFO, in_ready while fewer than two
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      int n;
      n = q.size();
      if (n > 0 && out_ready) begin
        void'(q.pop_front());
        pops++;
      end
      if (n < 2 && in_valid)
        q.push_back(model(16, 32, 2, {48'd0, in_data}, in_mode));
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    if (q.size() > 0)
      chk("out_data", {32'd0, out_data}, q[0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] d, logic [1:0] m);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    n = 0;
    do begin
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 20);
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_b(logic [7:0] d, logic [1:0] m,
                        logic [15:0] exp, string name);
    chk("b_in_ready", {63'd0, b_in_ready}, 64'd1);
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_mode  = m;
    step();
    b_in_valid = 1'b0;
    chk(name, {47'd0, b_out_valid, b_out_data}, {47'd1, exp});
  endtask

  initial begin
    int p0;

    chk("pin_sign55", model(16, 32, 2, 64'd55, 2'd0), 64'h37);
    chk("pin_sign8000", model(16, 32, 2, 64'h8000, 2'd0), 64'hFFFF_8000);
    chk("pin_zero", model(16, 32, 2, 64'h8000, 2'd1), 64'h0000_8000);
    chk("pin_upper", model(16, 32, 2, 64'h1234, 2'd2), 64'h1234_0000);
    chk("pin_brneg", model(16, 32, 2, 64'hFFFF, 2'd3), 64'hFFFF_FFFC);
    chk("pin_brpos", model(16, 32, 2, 64'h4000, 2'd3), 64'h0001_0000);
    chk("pin_b_br", model(8, 16, 1, 64'hC0, 2'd3), 64'hFF80);

    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    step();
    reset = 1'b0;
    step();

    out_ready = 1'b1;
    send(16'd55, 2'd0);
    chk("lat_sign55", {31'd0, out_valid, out_data}, {31'd1, 32'h37});
    send(16'h8000, 2'd0);
    chk("lat_sign8000", {32'd0, out_data}, 64'hFFFF_8000);
    send(16'h8000, 2'd1);
    chk("lat_zero", {32'd0, out_data}, 64'h0000_8000);
    send(16'h1234, 2'd2);
    chk("lat_upper", {32'd0, out_data}, 64'h1234_0000);
    send(16'hFFFF, 2'd3);
    chk("lat_brneg", {32'd0, out_data}, 64'hFFFF_FFFC);
    send(16'h4000, 2'd3);
    chk("lat_brpos", {32'd0, out_data}, 64'h0001_0000);
    step();
    chk("drained", {63'd0, out_valid}, 64'd0);

    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i * 16'h2345 + 16'h8001);
      in_mode  = 2'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stream_pops", 64'(pops - p0), 64'd8);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    in_mode   = 2'd0;
    step();
    in_data = 16'h1234;
    in_mode = 2'd2;
    step();
    in_data = 16'hFFFF;
    in_mode = 2'd3;
    chk("bp_full", {63'd0, in_ready}, 64'd0);
    step();
    chk("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_a", {32'd0, out_data}, 64'h1);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", {32'd0, out_data}, 64'h1234_0000);
    chk("bp_rdy_back", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_c", {32'd0, out_data}, 64'hFFFF_FFFC);
    step();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    out_ready = 1'b0;
    send(16'h0011, 2'd1);
    send(16'h0022, 2'd1);
    chk("mid_full", {63'd0, in_ready}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_out_data", {32'd0, out_data}, 64'd0);
    chk("mid_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = 16'h0BAD;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    chk("rst_ignored", {63'd0, out_valid}, 64'd0);
    step();
    out_ready = 1'b1;
    send(16'h00AB, 2'd1);
    chk("post_rst", {31'd0, out_valid, out_data}, {31'd1, 32'hAB});
    step();
    chk("post_alone", {63'd0, out_valid}, 64'd0);

    send_b(8'h80, 2'd0, 16'hFF80, "b_sign");
    send_b(8'hA5, 2'd2, 16'hA500, "b_upper");
    send_b(8'hC0, 2'd3, 16'hFF80, "b_branch");
    send_b(8'h80, 2'd1, 16'h0080, "b_zero");
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath, replacing the fixed 16→32 sign extender. Accepts an IN_W-bit immediate plus a 2-bit mode over a valid/ready handshake and returns an OUT_W-bit extended value one cycle later. The unit covers the sign-extend, zero-extend, LUI-style upper placement and branch-offset modes. A two-entry buffer (output register plus skid register) sustains full throughput under backpressure without a combinational ready path.

## Interface
Parameters:
- IN_W, 16, immediate width; must be ≥ 2
- OUT_W, 32, result width; must be > IN_W
- BR_SHIFT, 2, left shift applied in branch mode; 0 ≤ BR_SHIFT < OUT_W

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  producer offers in_data/in_mode
- in_ready  output  1  unit can accept; registered
- in_data  input  IN_W  immediate field
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  OUT_W  extended result; registered

## Operation
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Extension is computed combinationally at the input and then captured. s = in_data[IN_W-1].
  - 00 sign: {(OUT_W-IN_W){s}, in_data}.
  - 01 zero: {(OUT_W-IN_W){0}, in_data}.
  - 10 upper: in_data placed in the top IN_W bits; the low OUT_W-IN_W bits are 0.
  - 11 branch: the sign-extended value shifted left by BR_SHIFT. Bits beyond OUT_W are dropped, with no overflow flag.
- Storage: the head register (drives out_data/out_valid) and one skid register.
- Each edge, in priority order:
  - Head empty or being transferred out: the head loads from skid if skid is full. Otherwise it loads from the input if an input transfer occurs. Otherwise the head becomes empty.
  - Head full and stalled, with an input transfer: the input goes to skid.
  - When the head loads from skid and an input transfer also occurs, the input goes to skid.
- in_ready = !skid_full. It is registered, so there is no path from out_ready to in_ready.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- in_data/in_mode are don't-care when in_valid=0. in_valid may drop without a transfer.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - out_valid=0, out_data=0, in_ready=1.
  - Skid is empty.
  - Transfers at any edge while reset is high are ignored.
- Latency: an input accepted at edge N is presented with out_valid=1 after edge N. It transfers at edge N+1 if out_ready=1.
- Throughput: one result per cycle while out_ready=1 continuously.
- Backpressure:
  - After two accepts with no drain, in_ready=0 starting the cycle after the second accept.
  - in_ready returns to 1 the cycle after the first output transfer that empties skid.
- Stall behaviour: while out_valid=1 and out_ready=0, out_data is held stable.
- Full and draining: with the head transferring out and skid full, the head takes skid, and skid takes a new input only if in_ready was 1 at that edge. Because in_ready was 0, it stays 0 for that edge, so skid empties.
- Empty, with in_valid=1 and out_ready=1 together: the input is captured into the head. Nothing passes through combinationally.
- Reset mid-operation: both entries are discarded immediately. Outputs take their reset values without waiting for a clock edge.

## Test plan
- Defaults, mode 00: in_data 16'd55 → out_data 32'h0000_0037; in_data 16'h8000 → 32'hFFFF_8000. Each appears one cycle after accept.
- Modes on 16'h8000, 16'h1234, 16'hFFFF:
  - zero 16'h8000 → 32'h0000_8000.
  - upper 16'h1234 → 32'h1234_0000.
  - branch 16'hFFFF → 32'hFFFF_FFFC.
  - branch 16'h4000 → 32'h0001_0000.
- Streaming: 8 back-to-back inputs with out_ready=1 → 8 outputs in order on consecutive cycles, in_ready always 1.
- Backpressure: out_ready=0, offer A, B, C on consecutive cycles.
  - Expected: A and B accepted, in_ready=0 from the cycle after B, C held.
  - Raise out_ready: outputs A, B, C in order, with no loss or duplicates.
- Reset mid-operation: fill both entries, assert reset between edges.
  - Expected: out_valid=0, out_data=0, in_ready=1 immediately.
  - After release, the first new input emerges alone.
- Parameter sweep IN_W=8, OUT_W=16, BR_SHIFT=1: sign 8'h80 → 16'hFF80; upper 8'hA5 → 16'hA500; branch 8'hC0 → 16'hFF80.
